// File: rtl/blade_controller_if.sv
// blade_controller_if: handshake, error-rail and pulse signals of one blade pipeline stage
interface blade_controller_if;
    logic Lreq, Lack, Rreq, Rack, LEreq, LEack, REreq, REack, Err1, Err0, clk, sample;
    modport master (
        output Lreq, Rack, LEack, REreq, Err1, Err0,
        input  Lack, Rreq, LEreq, REack, clk, sample
    );
    modport slave (
        input  Lreq, Rack, LEack, REreq, Err1, Err0,
        output Lack, Rreq, LEreq, REack, clk, sample
    );
endinterface

// File: rtl/blade_controller.sv
// blade_controller: blade stage controller with error recovery; BLADE_CTRL_SYNC_EN adds 2-flop input synchronizers
module blade_controller #(
    parameter int CLK_HIGH     = 2,
    parameter int SAMPLE_DELAY = 3,
    parameter int CNT_W        = 4
) (
    input logic sys_clk,
    input logic rst,
    blade_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CAPTURE, WINDOW, EVAL, NULL, RECOVER, DONE} state_t;

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic err_flag, err_n;
    logic clk_q, clk_n, sample_q, sample_n;
    logic lack_q, lack_n, rreq_q, rreq_n, lereq_q, lereq_n, reack_q, reack_n;
    logic lreq, rack, leack, rereq, err1, err0;

`ifdef BLADE_CTRL_SYNC_EN
    logic [5:0] sync1, sync2;

    // two-stage synchronizer for every asynchronous input
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.Lreq, bus.Rack, bus.LEack, bus.REreq, bus.Err1, bus.Err0};
            sync2 <= sync1;
        end
    end

    assign {lreq, rack, leack, rereq, err1, err0} = sync2;
`else
    assign {lreq, rack, leack, rereq, err1, err0} =
        {bus.Lreq, bus.Rack, bus.LEack, bus.REreq, bus.Err1, bus.Err0};
`endif

    // state, counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            err_flag <= 1'b0;
            clk_q    <= 1'b0;
            sample_q <= 1'b0;
            lack_q   <= 1'b0;
            rreq_q   <= 1'b0;
            lereq_q  <= 1'b0;
            reack_q  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            err_flag <= err_n;
            clk_q    <= clk_n;
            sample_q <= sample_n;
            lack_q   <= lack_n;
            rreq_q   <= rreq_n;
            lereq_q  <= lereq_n;
            reack_q  <= reack_n;
        end
    end

    // next-state logic; channel return-to-zero runs regardless of state, FSM sets override it
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        err_n    = err_flag;
        clk_n    = clk_q;
        sample_n = sample_q;
        lack_n   = lack_q && lreq;
        rreq_n   = rreq_q && !rack;
        lereq_n  = lereq_q && !leack;
        reack_n  = reack_q ? rereq : (rereq && state == DONE);
        case (state)
            IDLE:
                if (lreq && !lack_q && !rreq_q && !rack && !lereq_q && !leack && !reack_q) begin
                    state_n = CAPTURE;
                    clk_n   = 1'b1;
                    cnt_n   = '0;
                end
            CAPTURE:
                if (cnt == CNT_W'(CLK_HIGH - 1)) begin
                    state_n = WINDOW;
                    clk_n   = 1'b0;
                    cnt_n   = '0;
                    lack_n  = 1'b1;
                    rreq_n  = 1'b1;
                    lereq_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            WINDOW:
                if (cnt == CNT_W'(SAMPLE_DELAY - 1)) begin
                    state_n  = EVAL;
                    sample_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            EVAL:
                if (err1 || err0) begin
                    state_n  = NULL;
                    err_n    = err1;
                    sample_n = 1'b0;
                end
            NULL:
                if (!err1 && !err0) begin
                    state_n = err_flag ? RECOVER : DONE;
                    clk_n   = err_flag;
                    cnt_n   = '0;
                end
            RECOVER:
                if (cnt == CNT_W'(CLK_HIGH - 1)) begin
                    state_n = DONE;
                    clk_n   = 1'b0;
                    err_n   = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            DONE:
                if (!lack_q && !rreq_q && !lereq_q && !leack && !reack_q && !rereq)
                    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.clk    = clk_q;
    assign bus.sample = sample_q;
    assign bus.Lack   = lack_q;
    assign bus.Rreq   = rreq_q;
    assign bus.LEreq  = lereq_q;
    assign bus.REack  = reack_q;
endmodule

// File: tb/tb_blade_controller.sv
// tb_blade_controller: directed scoreboard bench for blade_controller
module tb_blade_controller;
    typedef struct {
        int sig;
        int cyc;
    } ev_t;

    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    ev_t exp_q[$];
    logic [5:0] prev = '0;
    string nm[6] = '{"REack", "sample", "LEreq", "Rreq", "Lack", "clk"};

    blade_controller_if bus();

    blade_controller dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    // cycle k is the interval following the k-th rising edge
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [5:0] outs();
        return {bus.clk, bus.Lack, bus.Rreq, bus.LEreq, bus.sample, bus.REack};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int sig, input int at);
        exp_q.push_back('{sig, at});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // pops an expected rise for every output rising edge; clk and sample must never overlap
    always @(negedge sys_clk) begin
        logic [5:0] cur;
        ev_t ev;
        cur = outs();
        chk("clk_sample_excl", {31'b0, cur[5] & cur[1]}, 0);
        for (int i = 5; i >= 0; i--) begin
            if (cur[i] === 1'b1 && prev[i] === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk({"unexpected_", nm[i]}, cyc, -1);
                end else begin
                    ev = exp_q.pop_front();
                    chk({nm[i], "_rise_sig"}, i, ev.sig);
                    chk({nm[i], "_rise_cyc"}, cyc, ev.cyc);
                end
            end
        end
        prev = cur;
    end

    // kind: 0 Err0, 1 Err1, 2 both rails; hold keeps Rack low; le_late answers LEreq 10 cycles later
    task automatic token(input int kind, input bit hold, input bit le_late);
        int c;
        int r;
        c = cyc;
        bus.Lreq = 1'b1;
        bus.REreq = 1'b1;
        push(5, c + 1);
        push(4, c + 3);
        push(3, c + 3);
        push(2, c + 3);
        push(1, c + 6);
        step(3);
        chk("clk_low_after_capture", bus.clk, 0);
        bus.Lreq = 1'b0;
        bus.Rack = !hold;
        bus.LEack = !le_late;
        step(1);
        chk("lack_rtz", bus.Lack, 0);
        chk("rreq_rtz", bus.Rreq, hold);
        chk("lereq_rtz", bus.LEreq, le_late);
        bus.Rack = 1'b0;
        bus.LEack = 1'b0;
        step(2);
        bus.Err1 = kind != 0;
        bus.Err0 = kind != 1;
        step(1);
        chk("sample_drop", bus.sample, 0);
        bus.Err1 = 1'b0;
        bus.Err0 = 1'b0;
        if (kind != 0) push(5, c + 8);
        r = c + ((kind != 0) ? 11 : 9);
        push(0, r);
        step(r - cyc - 1);
        chk("reack_before_done", bus.REack, 0);
        step(1);
        chk("reack_set", bus.REack, 1);
        bus.REreq = 1'b0;
        step(1);
        chk("reack_rtz", bus.REack, 0);
        if (le_late) begin
            step(c + 13 - cyc);
            chk("lereq_held", bus.LEreq, 1);
            bus.LEack = 1'b1;
            step(1);
            chk("lereq_late_rtz", bus.LEreq, 0);
            bus.LEack = 1'b0;
        end
        step(1);
    endtask

    initial begin
        int c;
        {bus.Lreq, bus.Rack, bus.LEack, bus.REreq, bus.Err1, bus.Err0} = '0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset_outs", outs(), 0);
        end
        rst = 1'b0;
        step(1);
        token(0, 1'b0, 1'b0);
        token(1, 1'b0, 1'b0);
        token(2, 1'b0, 1'b1);
        c = cyc;
        token(0, 1'b1, 1'b0);
        bus.Lreq = 1'b1;
        step(c + 23 - cyc);
        chk("bp_rreq_held", bus.Rreq, 1);
        chk("bp_clk_low", bus.clk, 0);
        bus.Rack = 1'b1;
        step(1);
        chk("bp_rreq_rtz", bus.Rreq, 0);
        bus.Rack = 1'b0;
        step(1);
        token(0, 1'b0, 1'b0);
        c = cyc;
        bus.Lreq = 1'b1;
        push(5, c + 1);
        push(4, c + 3);
        push(3, c + 3);
        push(2, c + 3);
        step(4);
        rst = 1'b1;
        bus.Lreq = 1'b0;
        step(1);
        chk("midop_reset_outs", outs(), 0);
        rst = 1'b0;
        step(1);
        token(1, 1'b0, 1'b0);
        step(4);
        chk("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
